// File: rtl/layer_sched_ctrl.sv
// -----------------------------------------------------------------------------
// layer_sched_ctrl
// Top-level sequencer for the layered NN datapath. For every layer it launches
// one compute pass on the tile array, then one layer-readback pass per tile,
// handshaking with the compute controller (cmp_start/cmp_done) and the layering
// pipeline controller (lay_start/lay_busy). It owns tile_idx/layer_idx and the
// select of the shared valid_ctrl mux, and talks to the host via run/busy/done.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   run           start a full run (accepted only in IDLE, not with abort)
//   abort         return to IDLE next cycle, indices and err kept
//   cmp_start     one-cycle start pulse to the compute controller
//   cmp_done      compute pass complete (level or pulse)
//   lay_start     one-cycle start pulse to the layering controller
//   lay_busy      busy flag from the layering controller
//   acc_valid     accumulators hold settled results
//   layer_ready   acc_valid qualified by LAY_WAIT (combinational)
//   sel_layer     valid_ctrl mux select: 1 = layering ctrl, 0 = compute ctrl
//   tile_idx      current readback tile
//   layer_idx     current layer
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the last readback of the last layer
//   err           sticky watchdog error, cleared by the next accepted run
// -----------------------------------------------------------------------------
module layer_sched_ctrl #(
  parameter int N_TILES  = 4,
  parameter int N_LAYERS = 3,
  parameter int TIDX_W   = 2,
  parameter int LIDX_W   = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              abort,
  output logic              cmp_start,
  input  logic              cmp_done,
  output logic              lay_start,
  input  logic              lay_busy,
  input  logic              acc_valid,
  output logic              layer_ready,
  output logic              sel_layer,
  output logic [TIDX_W-1:0] tile_idx,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMP_GO, S_CMP_WAIT, S_LAY_GO, S_LAY_WAIT, S_ADV, S_DONE
  } state_t;

  localparam logic [TIDX_W-1:0] TILE_LAST  = TIDX_W'(N_TILES - 1);
  localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(N_LAYERS - 1);
  // The watchdog fires on the edge where the count would reach WAIT_MAX, so a
  // wait state lasts at most WAIT_MAX cycles before falling back to IDLE.
  localparam logic [7:0]        WDOG_LAST  = 8'(WAIT_MAX - 1);

  state_t              r_state;
  state_t              w_next;
  logic [TIDX_W-1:0]   r_tile;
  logic [LIDX_W-1:0]   r_layer;
  logic [7:0]          r_wdog;
  logic                r_seen_busy;
  logic                r_err;
  logic                r_cmp_start;
  logic                r_lay_start;
  logic                r_sel_layer;
  logic                r_busy;
  logic                r_done;
  logic                w_timeout;
  logic                w_wdog_last;
  logic                w_lay_exit;
  logic                w_accept;

  assign w_wdog_last = (r_wdog == WDOG_LAST);
  // Leave LAY_WAIT only after the layering controller has been seen busy and
  // has dropped busy again; this guarantees at least two cycles of dwell.
  assign w_lay_exit  = r_seen_busy & ~lay_busy;
  assign w_accept    = (r_state == S_IDLE) & (w_next == S_CMP_GO);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:     if (run) w_next = S_CMP_GO;
      S_CMP_GO:   w_next = S_CMP_WAIT;
      S_CMP_WAIT: begin
        if (cmp_done) begin
          w_next = S_LAY_GO;
        end else if (w_wdog_last) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_LAY_GO:   w_next = S_LAY_WAIT;
      S_LAY_WAIT: begin
        if (w_lay_exit) begin
          w_next = S_ADV;
        end else if (w_wdog_last) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_ADV: begin
        if (r_tile != TILE_LAST)        w_next = S_LAY_GO;
        else if (r_layer != LAYER_LAST) w_next = S_CMP_GO;
        else                            w_next = S_DONE;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next    = S_IDLE;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tile      <= '0;
      r_layer     <= '0;
      r_wdog      <= '0;
      r_seen_busy <= 1'b0;
      r_err       <= 1'b0;
      r_cmp_start <= 1'b0;
      r_lay_start <= 1'b0;
      r_sel_layer <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Registered outputs are decoded from the next state so they line up
      // exactly with the state they belong to.
      r_cmp_start <= (w_next == S_CMP_GO);
      r_lay_start <= (w_next == S_LAY_GO);
      r_sel_layer <= (w_next == S_LAY_GO) || (w_next == S_LAY_WAIT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);

      if (w_accept) begin
        r_tile  <= '0;
        r_layer <= '0;
        r_err   <= 1'b0;
      end else if ((r_state == S_ADV) && !abort) begin
        if (r_tile != TILE_LAST) begin
          r_tile <= r_tile + TIDX_W'(1);
        end else begin
          r_tile <= '0;
          if (r_layer != LAYER_LAST) r_layer <= r_layer + LIDX_W'(1);
        end
      end

      if (w_timeout) r_err <= 1'b1;

      if (r_state == S_LAY_GO)                   r_seen_busy <= 1'b0;
      else if ((r_state == S_LAY_WAIT) && lay_busy) r_seen_busy <= 1'b1;

      if ((r_state == S_CMP_GO) || (r_state == S_LAY_GO))
        r_wdog <= '0;
      else if ((r_state == S_CMP_WAIT) || (r_state == S_LAY_WAIT))
        r_wdog <= r_wdog + 8'd1;
    end
  end

  assign cmp_start   = r_cmp_start;
  assign lay_start   = r_lay_start;
  assign sel_layer   = r_sel_layer;
  assign tile_idx    = r_tile;
  assign layer_idx   = r_layer;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign layer_ready = (r_state == S_LAY_WAIT) & acc_valid;

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layer_sched_ctrl
// Scoreboard bench for layer_sched_ctrl. The stimulus pushes the expected
// sequence of strobe events (compute start, readback start, done, each tagged
// with the layer/tile indices it must carry) into a queue; a separate monitor
// pops and compares whenever the DUT raises a strobe. Peer controllers are
// modelled with configurable (randomised) latencies, and the run latency is
// predicted from those latencies with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_layer_sched_ctrl;
  localparam int NT = 2;
  localparam int NL = 2;
  localparam int WM = 10;

  logic       clk = 1'b0;
  logic       rst, run, abort, cmp_done, cmp_done_peer, cmp_spur, lay_busy;
  logic       acc_valid = 1'b0;
  logic       cmp_start, lay_start, layer_ready, sel_layer, busy, done, err;
  logic [1:0] tile_idx, layer_idx;

  int cmp_dly = 0, lay_dly = 0, lay_hold = 1;
  bit cmp_never = 1'b0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_cmp = 0, n_lay = 0, n_done = 0;
  int exp_q[$];
  int t_run = 0;

  assign cmp_done = cmp_done_peer | cmp_spur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_sched_ctrl #(
    .N_TILES(NT), .N_LAYERS(NL), .TIDX_W(2), .LIDX_W(2), .WAIT_MAX(WM)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .cmp_start(cmp_start), .cmp_done(cmp_done),
    .lay_start(lay_start), .lay_busy(lay_busy), .acc_valid(acc_valid),
    .layer_ready(layer_ready), .sel_layer(sel_layer),
    .tile_idx(tile_idx), .layer_idx(layer_idx),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Event code: kind (1=compute start, 2=readback start, 4=done) plus indices.
  function automatic int ev(input int kind, input int l, input int t);
    return kind * 100 + l * 10 + t;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_full_run();
    for (int l = 0; l < NL; l++) begin
      exp_q.push_back(ev(1, l, 0));
      for (int t = 0; t < NT; t++) exp_q.push_back(ev(2, l, t));
    end
    exp_q.push_back(ev(4, NL - 1, 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmp_start"}, int'(cmp_start), 0);
    chk({tag, "_lay_start"}, int'(lay_start), 0);
    chk({tag, "_layer_ready"}, int'(layer_ready), 0);
    chk({tag, "_sel_layer"}, int'(sel_layer), 0);
    chk({tag, "_tile_idx"}, int'(tile_idx), 0);
    chk({tag, "_layer_idx"}, int'(layer_idx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic do_run();
    tick();
    run = 1'b1;
    @(negedge clk);
    t_run = cyc;
    tick();
    run = 1'b0;
  endtask

  // Full run with the current peer latencies; optionally disturbs it with a
  // run pulse and a spurious cmp_done while the DUT waits on the layering ctrl.
  task automatic run_check(input string tag, input bit disturb);
    int s_cmp, s_lay, s_done, lat, t_done;
    bit ok;
    s_cmp = n_cmp; s_lay = n_lay; s_done = n_done;
    lat = NL * (2 + cmp_dly + NT * (3 + lay_dly + lay_hold)) + 1;
    push_full_run();
    do_run();
    @(negedge clk);
    chk({tag, "_busy_after_run"}, int'(busy), 1);
    chk({tag, "_err_after_run"}, int'(err), 0);
    if (disturb) begin
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (lay_start) break; end
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (lay_busy) break; end
      tick();
      run = 1'b1; cmp_spur = 1'b1;
      tick();
      run = 1'b0; cmp_spur = 1'b0;
    end
    ok = 1'b0;
    t_done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; t_done = cyc; break; end
    end
    chk({tag, "_done_seen"}, int'(ok), 1);
    chk({tag, "_done_latency"}, t_done - t_run, lat);
    @(negedge clk);
    chk({tag, "_busy_after_done"}, int'(busy), 0);
    chk({tag, "_done_single"}, int'(done), 0);
    chk({tag, "_n_cmp_start"}, n_cmp - s_cmp, NL);
    chk({tag, "_n_lay_start"}, n_lay - s_lay, NL * NT);
    chk({tag, "_n_done"}, n_done - s_done, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops the scoreboard on every strobe and checks context signals.
  initial begin : monitor
    int got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmp_start || lay_start || done) begin
          got = ev(int'({done, lay_start, cmp_start}), int'(layer_idx), int'(tile_idx));
          if (exp_q.size() == 0) chk("unexpected_event", got, -1);
          else chk("event_seq", got, exp_q.pop_front());
          if (cmp_start) begin
            n_cmp++;
            chk("ready_in_cmp_go", int'(layer_ready), 0);
            chk("sel_in_cmp_go", int'(sel_layer), 0);
          end
          if (lay_start) begin
            n_lay++;
            chk("lay_busy_low_at_lay_start", int'(lay_busy), 0);
            chk("sel_in_lay_go", int'(sel_layer), 1);
          end
          if (done) begin
            n_done++;
            chk("ready_in_done", int'(layer_ready), 0);
          end
        end
        if (lay_busy && busy) begin
          chk("ready_follows_acc", int'(layer_ready), int'(acc_valid));
          chk("sel_in_lay_wait", int'(sel_layer), 1);
        end
      end
    end
  end

  // Peer model: compute and layering controllers with programmable latency.
  initial begin : peers
    cmp_done_peer = 1'b0;
    lay_busy      = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_start && !cmp_never) begin
        tick();
        repeat (cmp_dly) tick();
        cmp_done_peer = 1'b1;
        tick();
        cmp_done_peer = 1'b0;
      end else if (lay_start) begin
        tick();
        repeat (lay_dly) tick();
        lay_busy = 1'b1;
        repeat (lay_hold) tick();
        lay_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    acc_valid = 1'($urandom_range(0, 1));
  end

  initial begin : guard
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s_cmp, s_done, t_err, cnt;
    bit ok;
    rst = 1'b1; run = 1'b0; abort = 1'b0; cmp_spur = 1'b0;

    // T1: reset
    repeat (2) tick();
    @(negedge clk);
    check_zero("rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // T2: ideal peers
    cmp_dly = 0; lay_dly = 0; lay_hold = 1;
    run_check("t2", 1'b0);

    // T3: lay_busy held 3 cycles per pass
    lay_hold = 3;
    run_check("t3", 1'b0);

    // T4: compute never completes -> watchdog
    lay_hold = 1; cmp_never = 1'b1;
    s_done = n_done;
    exp_q.push_back(ev(1, 0, 0));
    do_run();
    ok = 1'b0; t_err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err) begin ok = 1'b1; t_err = cyc; break; end
    end
    chk("t4_err_seen", int'(ok), 1);
    chk("t4_err_latency", t_err - t_run, WM + 2);
    chk("t4_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", int'(err), 1);
    chk("t4_no_done", n_done - s_done, 0);
    chk("t4_queue_empty", exp_q.size(), 0);
    cmp_never = 1'b0;
    run_check("t4_rerun", 1'b0);

    // T5: abort during second LAY_WAIT, run in the same cycle
    s_cmp = n_cmp; s_done = n_done;
    push_full_run();
    do_run();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lay_start) cnt++;
      if (cnt == 2) break;
    end
    tick();
    abort = 1'b1; run = 1'b1;
    tick();
    abort = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_sel_layer", int'(sel_layer), 0);
    chk("t5_tile_kept", int'(tile_idx), 1);
    chk("t5_layer_kept", int'(layer_idx), 0);
    chk("t5_lay_start", int'(lay_start), 0);
    chk("t5_err", int'(err), 0);
    repeat (12) @(negedge clk);
    chk("t5_no_done", n_done - s_done, 0);
    chk("t5_no_restart", n_cmp - s_cmp, 1);
    exp_q.delete();

    // T6: run while busy plus spurious cmp_done in LAY_WAIT
    lay_hold = 2;
    run_check("t6", 1'b1);

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      cmp_dly  = int'($urandom_range(0, 3));
      lay_dly  = int'($urandom_range(0, 3));
      lay_hold = int'($urandom_range(1, 4));
      run_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the second layer
    cmp_dly = 0; lay_dly = 0; lay_hold = 1;
    push_full_run();
    do_run();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmp_start) cnt++;
      if (cnt == 2) break;
    end
    chk("rst_mid_layer_idx_before", int'(layer_idx), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_zero("rst_mid");
    s_cmp = n_cmp;
    repeat (10) @(negedge clk);
    chk("rst_mid_quiet", n_cmp - s_cmp, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
